// File: rtl/window_gen_5x5.sv
// rtl/window_gen_5x5.sv - streaming 5x5 neighbourhood generator for the Gaussian stage
//
// Accepts one raster-order pixel per in_valid/in_ready handshake, keeps the four
// previous image lines in line buffers and emits a packed 25-pixel window for
// every pixel position that has a full 5x5 neighbourhood (no border padding).
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high
//   in_data    pixel, raster order
//   in_valid   in_data valid
//   in_ready   block can accept a pixel this cycle (!out_valid || out_ready)
//   out_data   packed window, element (r,c) at [(r*5+c)*PIXEL_WIDTH +: PIXEL_WIDTH]
//   out_valid  out_data valid
//   out_ready  downstream accepts the window this cycle
//   out_last   window whose bottom-right pixel is the last pixel of the frame

module window_gen_5x5 #(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int DWIDTH_OUT  = PIXEL_WIDTH * 25
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [PIXEL_WIDTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DWIDTH_OUT-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_WIN0 = CW'(4);
  localparam logic [RW-1:0] ROW_WIN0 = RW'(4);

  // Raster position of the next pixel to be accepted.
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  // r_lb[k][x] holds pixel (y-1-k, x) relative to the row y currently being received.
  logic [PIXEL_WIDTH-1:0] r_lb [4][IMG_WIDTH];

  // Sliding 5x5 window; [r][c], r=0 oldest row, c=4 newest column.
  logic [PIXEL_WIDTH-1:0] r_win [5][5];

  logic                   r_out_valid;
  logic                   r_out_last;
  logic [DWIDTH_OUT-1:0]  r_out_data;

  logic                   w_accept;
  logic                   w_col_wrap;
  logic                   w_row_wrap;
  logic                   w_emit;
  logic                   w_last;
  logic [PIXEL_WIDTH-1:0] w_col_new [5];
  logic [PIXEL_WIDTH-1:0] w_win_next [5][5];
  logic [DWIDTH_OUT-1:0]  w_win_flat;

  // Single output register without skid: a new pixel may only enter when the
  // held window is empty or leaving this cycle.
  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;

  assign w_col_wrap = (r_col == COL_LAST);
  assign w_row_wrap = (r_row == ROW_LAST);
  assign w_emit     = (r_row >= ROW_WIN0) && (r_col >= COL_WIN0);
  assign w_last     = w_row_wrap && w_col_wrap;

  // New rightmost column: four buffered rows at the current column plus the
  // incoming pixel at the bottom.
  always_comb begin
    w_col_new[0] = r_lb[3][r_col];
    w_col_new[1] = r_lb[2][r_col];
    w_col_new[2] = r_lb[1][r_col];
    w_col_new[3] = r_lb[0][r_col];
    w_col_new[4] = in_data;
  end

  always_comb begin
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_win_next[r][c] = r_win[r][c+1];
      end
      w_win_next[r][4] = w_col_new[r];
    end
  end

  always_comb begin
    w_win_flat = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        w_win_flat[(r*5+c)*PIXEL_WIDTH +: PIXEL_WIDTH] = w_win_next[r][c];
      end
    end
  end

  // Data storage is deliberately not reset: after a reset the row counter
  // suppresses output until four fresh lines have overwritten every entry.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_lb[0][r_col] <= in_data;
      r_lb[1][r_col] <= r_lb[0][r_col];
      r_lb[2][r_col] <= r_lb[1][r_col];
      r_lb[3][r_col] <= r_lb[2][r_col];
      r_win          <= w_win_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_col       <= '0;
      r_row       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_col_wrap) begin
          r_col <= '0;
          r_row <= w_row_wrap ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        // An accept implies any held window is being consumed this cycle, so
        // the output register simply takes the new state.
        r_out_valid <= w_emit;
        if (w_emit) begin
          r_out_data <= w_win_flat;
          r_out_last <= w_last;
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_window_gen_5x5.sv
// tb/tb_window_gen_5x5.sv - self-checking bench for window_gen_5x5 (8x6 image)

module tb_window_gen_5x5;

  localparam int PW = 8;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DW = PW * 25;

  logic          clock = 1'b0;
  logic          reset;
  logic [PW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  window_gen_5x5 #(
    .PIXEL_WIDTH(PW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .DWIDTH_OUT (DW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  logic [PW-1:0] img [H][W];
  logic [DW-1:0] exp_data_q [$];
  logic          exp_last_q [$];
  logic [DW-1:0] cap_data [$];
  logic          cap_last [$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [PW-1:0] px(input logic [DW-1:0] w, input int k);
    return w[k*PW +: PW];
  endfunction

  function automatic logic [DW-1:0] capw(input int k);
    if (k < cap_data.size()) return cap_data[k];
    return '0;
  endfunction

  function automatic logic capl(input int k);
    if (k < cap_last.size()) return cap_last[k];
    return 1'b0;
  endfunction

  // Window whose bottom-right pixel is (r,c), straight from the packing rule.
  function automatic logic [DW-1:0] model_win(input int r, input int c);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        w[(i*5+j)*PW +: PW] = img[r-4+i][c-4+j];
    return w;
  endfunction

  function automatic logic [PW-1:0] pix_val(input int base, input int p);
    return PW'(base + (p / W) * 16 + (p % W));
  endfunction

  task automatic send_pixel(input int r, input int c, input logic [PW-1:0] v);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = v;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
    end
    if (!acc) begin
      n_checks++;
      $display("FAIL send_timeout: pixel (%0d,%0d) not accepted within 200 cycles", r, c);
    end else begin
      img[r][c] = v;
      if (r >= 4 && c >= 4) begin
        exp_data_q.push_back(model_win(r, c));
        exp_last_q.push_back(r == H-1 && c == W-1);
      end
    end
  endtask

  task automatic send_span(input int base, input int p_from, input int p_to);
    for (int p = p_from; p < p_to; p++) send_pixel(p / W, p % W, pix_val(base, p));
  endtask

  task automatic drain();
    in_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
  endtask

  // Every cycle: a window is pending in the model exactly when out_valid is
  // high, and each handshake must carry the model's oldest window.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("valid_vs_model", out_valid, exp_data_q.size() != 0);
      if (out_valid && out_ready && exp_data_q.size() != 0) begin
        chk("window_data", out_data, exp_data_q[0]);
        chk("window_last", out_last, exp_last_q[0]);
        cap_data.push_back(out_data);
        cap_last.push_back(out_last);
        void'(exp_data_q.pop_front());
        void'(exp_last_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    int nl;
    int first_k;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    @(negedge clock);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_data", out_data, '0);
    chk("reset_out_last", out_last, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk_en = 1'b1;
    @(posedge clock);
    #1;

    // One frame, free-flowing output.
    cap_data.delete(); cap_last.delete();
    send_span(0, 0, W*H);
    drain();
    chk("t1_window_count", cap_data.size(), 8);
    chk("t2_first_idx0", px(capw(0), 0), 8'h00);
    chk("t2_first_idx4", px(capw(0), 4), 8'h04);
    chk("t2_first_idx12", px(capw(0), 12), 8'h22);
    chk("t2_first_idx20", px(capw(0), 20), 8'h40);
    chk("t2_first_idx24", px(capw(0), 24), 8'h44);
    chk("t2_first_last", capl(0), 1'b0);
    chk("t3_final_idx0", px(capw(7), 0), 8'h13);
    chk("t3_final_idx24", px(capw(7), 24), 8'h57);
    chk("t3_final_last", capl(7), 1'b1);
    bad = 0;
    nl  = 0;
    for (int k = 0; k < cap_data.size(); k++) begin
      if (px(cap_data[k], 24) % 16 < 4) bad++;
      if (cap_last[k]) nl++;
    end
    chk("t3_no_border_windows", bad, 0);
    chk("t3_last_count", nl, 1);

    // Backpressure at the first window.
    cap_data.delete(); cap_last.delete();
    out_ready = 1'b0;
    send_span(0, 0, 4*W + 5);
    in_valid = 1'b1;
    in_data  = pix_val(0, 4*W + 5);
    for (int t = 0; t < 10; t++) begin
      @(negedge clock);
      chk("t4_hold_in_ready", in_ready, 1'b0);
      chk("t4_hold_out_valid", out_valid, 1'b1);
      chk("t4_hold_out_data", out_data, exp_data_q.size() != 0 ? exp_data_q[0] : '0);
    end
    chk("t4_hold_idx24", px(out_data, 24), 8'h44);
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    send_span(0, 4*W + 5, W*H);
    drain();
    chk("t4_window_count", cap_data.size(), 8);
    chk("t4_first_idx24", px(capw(0), 24), 8'h44);
    chk("t4_next_idx24", px(capw(1), 24), 8'h45);

    // Two back-to-back frames, second offset by 0x80.
    cap_data.delete(); cap_last.delete();
    send_span(0, 0, W*H);
    send_span(8'h80, 0, W*H);
    drain();
    chk("t5_window_count", cap_data.size(), 16);
    bad = 0;
    for (int k = 0; k < cap_data.size(); k++)
      for (int e = 0; e < 25; e++)
        if ((px(cap_data[k], e) >= 8'h80) != (k >= 8)) bad++;
    chk("t5_frame_separation", bad, 0);
    chk("t5_f2_first_idx0", px(capw(8), 0), 8'h80);
    chk("t5_f1_last", capl(7), 1'b1);
    chk("t5_f2_last", capl(15), 1'b1);

    // Reset mid-frame, one cycle after pixel (5,2) is accepted.
    cap_data.delete(); cap_last.delete();
    send_span(0, 0, 5*W + 3);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clock);
    #1;
    exp_data_q.delete();
    exp_last_q.delete();
    reset = 1'b0;
    chk("t6_reset_out_valid", out_valid, 1'b0);
    chk("t6_reset_in_ready", in_ready, 1'b1);
    first_k = 0;
    for (int k = 1; k <= W*H; k++) begin
      send_pixel((k-1) / W, (k-1) % W, pix_val(0, k-1));
      if (first_k == 0 && out_valid === 1'b1) first_k = k;
    end
    drain();
    chk("t6_first_window_accepts", first_k, 37);
    chk("t6_window_count", cap_data.size(), 12);
    chk("t6_restart_idx24", px(capw(4), 24), 8'h44);
    chk("t6_restart_idx0", px(capw(4), 0), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
